// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI bus arbiter: FSM states, owner encoding and counter width.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN_FLASH,
    OWN_RAM,
    GAP
  } arb_state_t;

  typedef enum logic {
    FLASH = 1'b0,
    RAM   = 1'b1
  } owner_t;

  localparam int unsigned HOLD_W = 16;

endpackage

// File: rtl/spi_bus_arbiter.sv
// Round-robin sharer of one SPI bus between the flash reader and the RAM controller,
// with a CS-high turnaround gap between owners and per-device chip selects.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned MAX_HOLD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_flash,
  output logic              gnt_flash,
  input  logic              req_ram,
  output logic              gnt_ram,
  input  logic              flash_clk,
  input  logic              flash_mosi,
  input  logic              flash_cs_n,
  input  logic              ram_clk,
  input  logic              ram_mosi,
  input  logic              ram_cs_n,
  output logic              flash_miso,
  output logic              ram_miso,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_N_FLASH,
  output logic              CS_N_RAM,
  input  logic              clr_overrun,
  output logic              busy,
  output logic [HOLD_W-1:0] hold_cycles,
  output logic              overrun
);

  localparam logic [7:0]        GapLast   = 8'(GAP_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HoldLimit = HOLD_W'(MAX_HOLD - 1);
  localparam bit                HoldCheck = (MAX_HOLD != 0);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  arb_state_t        r_state;
  owner_t            r_last;
  logic              r_gnt_flash;
  logic              r_gnt_ram;
  logic [7:0]        r_gap_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic              r_overrun;
  logic              w_owning;

  // Assertion is immediate through the flop resets; deassertion takes two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n  = r_rst_sync[1];
  assign w_owning = (r_state == OWN_FLASH) || (r_state == OWN_RAM);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= IDLE;
      r_last      <= RAM;
      r_gnt_flash <= 1'b0;
      r_gnt_ram   <= 1'b0;
      r_gap_cnt   <= 8'd0;
      r_hold      <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
      // Set is evaluated after clear so it wins when both happen together.
      if (w_owning) begin
        if (r_hold != '1) begin
          r_hold <= r_hold + HOLD_W'(1);
        end
        if (HoldCheck && (r_hold == HoldLimit)) begin
          r_overrun <= 1'b1;
        end
      end

      unique case (r_state)
        IDLE: begin
          if (req_flash && (!req_ram || (r_last == RAM))) begin
            r_state     <= OWN_FLASH;
            r_gnt_flash <= 1'b1;
            r_hold      <= '0;
          end else if (req_ram) begin
            r_state   <= OWN_RAM;
            r_gnt_ram <= 1'b1;
            r_hold    <= '0;
          end
        end
        OWN_FLASH: begin
          if (!req_flash) begin
            r_state     <= GAP;
            r_gnt_flash <= 1'b0;
            r_last      <= FLASH;
            r_gap_cnt   <= 8'd0;
          end
        end
        OWN_RAM: begin
          if (!req_ram) begin
            r_state   <= GAP;
            r_gnt_ram <= 1'b0;
            r_last    <= RAM;
            r_gap_cnt <= 8'd0;
          end
        end
        GAP: begin
          if (r_gap_cnt == GapLast) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus mux: combinational from registered state, mode-0 idle when nobody owns the bus.
  always_comb begin
    SCK        = 1'b0;
    MOSI       = 1'b0;
    CS_N_FLASH = 1'b1;
    CS_N_RAM   = 1'b1;
    flash_miso = 1'b0;
    ram_miso   = 1'b0;
    unique case (r_state)
      OWN_FLASH: begin
        SCK        = flash_clk;
        MOSI       = flash_mosi;
        CS_N_FLASH = flash_cs_n;
        flash_miso = MISO;
      end
      OWN_RAM: begin
        SCK      = ram_clk;
        MOSI     = ram_mosi;
        CS_N_RAM = ram_cs_n;
        ram_miso = MISO;
      end
      default: ;
    endcase
  end

  assign gnt_flash   = r_gnt_flash;
  assign gnt_ram     = r_gnt_ram;
  assign busy        = (r_state != IDLE);
  assign hold_cycles = r_hold;
  assign overrun     = r_overrun;

endmodule
